fpu_cmp_arbiter: RTL and testbench
==================================

Name: fpu_cmp_arbiter

Overview:
Shares one fpuComp16 comparator between NUM_REQ independent requesters using round-robin arbitration. Each request carries two fp16 operands and an opcode: compare, min or max. The winning request goes through the shared classifier/comparator, and the result lands in a single registered response slot with valid/ready backpressure. The block sits between the scalar issue ports and the shared FP16 compare datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of requester index

Ports:
clock  input  1  system clock, rising edge
reset_L  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_a  input  NUM_REQ x 16 (packed fp16_t array)  operand A per requester
req_b  input  NUM_REQ x 16  operand B per requester
req_op  input  NUM_REQ x 2 (cmp_op_t)  00=CMP, 01=MIN, 10=MAX, 11=reserved
resp_valid  output  1  response slot holds a result
resp_ready  input  1  consumer accepts the response
resp_id  output  ID_W  index of the requester that produced the result
resp_flags  output  4  {unord, gt, eq, lt}
resp_value  output  16  MIN/MAX result; 16'h0000 for CMP

Behaviour:
- Reset: clock is the single clock; reset_L is asynchronous and active-low. While reset_L=0: resp_valid=0, resp_id=0, resp_flags=0, resp_value=0, rr_ptr=0, req_ready=0.
- Slot free: slot_free = ~resp_valid | resp_ready. This allows a same-cycle drain and refill, so one result per cycle is sustained.
- Arbitration (combinational):
  - When slot_free is 1, grant the first asserted req_valid starting at index rr_ptr and wrapping modulo NUM_REQ.
  - req_ready[g]=1 only for the granted index. All bits are 0 when slot_free is 0 or no request is valid.
  - A transfer happens when req_valid[i] & req_ready[i].
- Pointer update: on a transfer, rr_ptr <= (g+1) mod NUM_REQ. It is unchanged otherwise. With NUM_REQ not a power of two, the wrap is explicit and not bit truncation.
- Latency: exactly 1 cycle. A request accepted at edge N appears on resp_* after edge N with resp_valid=1.
- Response hold: resp_* stay stable while resp_valid & ~resp_ready. If resp_ready=1 and there is no new transfer, resp_valid <= 0.
- Datapath:
  - Classify each operand. isNaN means exp=5'h1F and frac!=0. isInf means exp=5'h1F and frac=0.
  - Feed the granted operands to fpuComp16.
  - unord = isNaN(a) | isNaN(b). lt, eq and gt are taken straight from the comparator, so all three are 0 when unord=1.
  - -0 vs +0: the comparator orders -0 < +0. MIN(-0,+0)=-0 and MAX(-0,+0)=+0.
- MIN/MAX rules:
  - MIN returns a when lt|eq, else b. MAX returns a when gt|eq, else b.
  - If exactly one operand is NaN, return the other operand.
  - If both are NaN, return the canonical qNaN 16'h7E00.
  - For MIN/MAX, flags are still reported.
- Reserved op 11 is accepted and completes normally with resp_flags=0 and resp_value=0. It must never hang a requester.
- Requester obligations: req_a, req_b and req_op must be stable while req_valid is high and not yet accepted. Dropping req_valid before acceptance is allowed and produces no response.
- Reset mid-operation: a pending response is discarded. Nothing is replayed after reset.
- Fairness: with all requesters continuously valid and resp_ready=1, the grant order is 0,1,…,NUM_REQ-1,0,… and no requester waits more than NUM_REQ-1 grants.

Decomposition:
- Shared package fpu_pkg holds:
  - fp16_t (sign/exp/frac), used as-is;
  - cmp_op_t enum;
  - FP16_QNAN = 16'h7E00 and FP16_EXP_MAX = 5'h1F;
  - the flag bit positions.
- Sub-module rr_arbiter (NUM_REQ; inputs req, en, ptr; outputs one-hot grant and index) carries the wrap-around priority search.
- The operand classification is a small function placed in fpu_pkg.
- fpuComp16 is instantiated once.

Test Plan:
- Single request: requester 2, CMP, a=16'h3C00 (1.0), b=16'h4000 (2.0) -> next cycle resp_valid=1, resp_id=2, flags=4'b0001.
- Round-robin: all four valid, MAX(16'hC000, 16'h3C00), resp_ready=1 -> resp_id sequence 0,1,2,3,0 on consecutive cycles, each resp_value=16'h3C00. Also rerun with NUM_REQ=3 -> sequence 0,1,2,0.
- Backpressure: resp_ready=0 for 3 cycles with req_valid[1]=1 -> req_ready=0, resp_* held stable. resp_ready=1 -> same-cycle drain and new accept, no bubble.
- NaN/zero cases:
  - MIN(16'h7E01, 16'h3C00) -> value 16'h3C00, flags 4'b1000.
  - MAX(NaN, NaN) -> 16'h7E00.
  - MIN(16'h8000, 16'h0000) -> 16'h8000, flags 4'b0001.
- Infinities: CMP(16'hFC00, 16'hFC00) -> eq. CMP(16'h7C00, 16'h7BFF) -> gt. CMP(16'hFC00, 16'h7C00) -> lt.
- Reset: assert reset_L=0 asynchronously while resp_valid=1 -> resp_valid=0 immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP16 types, constants and operand classification helpers.
//   fp16_t       - half-precision value split into sign / exponent / fraction
//   cmp_op_t     - compare-unit opcode (CMP, MIN, MAX, reserved)
//   FP16_QNAN    - canonical quiet NaN returned by MIN/MAX when both inputs are NaN
//   FLAG_*       - bit positions inside the 4-bit {unord, gt, eq, lt} flag vector
package fpu_pkg;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } fp16_t;

    typedef enum logic [1:0] {
        OP_CMP  = 2'b00,
        OP_MIN  = 2'b01,
        OP_MAX  = 2'b10,
        OP_RSVD = 2'b11
    } cmp_op_t;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

    localparam int FLAG_LT    = 0;
    localparam int FLAG_EQ    = 1;
    localparam int FLAG_GT    = 2;
    localparam int FLAG_UNORD = 3;

    function automatic logic fp16_is_nan(input fp16_t x);
        return (x.exp == FP16_EXP_MAX) && (x.frac != 10'd0);
    endfunction

    function automatic logic fp16_is_inf(input fp16_t x);
        return (x.exp == FP16_EXP_MAX) && (x.frac == 10'd0);
    endfunction

endpackage

// File: rtl/fpuComp16.sv
// fpuComp16: FP16 ordering comparator.
//   a, b        - fp16 operands
//   lt, eq, gt  - a<b, a==b, a>b; all zero when either operand is NaN
// -0 is ordered strictly below +0.
module fpuComp16
    import fpu_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        lt,
    output logic        eq,
    output logic        gt
);

    logic [15:0] key_a;
    logic [15:0] key_b;
    logic        unord;

    // Sign-magnitude to monotonic unsigned key: negatives are bit-inverted,
    // positives get the top bit set. -0 maps to 16'h7FFF, +0 to 16'h8000.
    assign key_a = a[15] ? ~a : (a | 16'h8000);
    assign key_b = b[15] ? ~b : (b | 16'h8000);
    assign unord = fp16_is_nan(a) | fp16_is_nan(b);

    assign lt = ~unord & (key_a <  key_b);
    assign eq = ~unord & (key_a == key_b);
    assign gt = ~unord & (key_a >  key_b);

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin priority search.
//   req   - request vector, one bit per requester
//   en    - when low no grant is issued
//   ptr   - index holding highest priority this cycle (always < NUM_REQ)
//   grant - one-hot grant (all zero when en=0 or no request)
//   idx   - binary index of the granted requester (0 when no grant)
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    // Walk NUM_REQ positions starting at ptr; the wrap is an explicit
    // subtraction so non-power-of-two requester counts stay in range.
    always_comb begin
        int   cand;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (en && !found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fpu_cmp_arbiter.sv
// fpu_cmp_arbiter: round-robin sharing of one FP16 comparator between
// NUM_REQ requesters, with a single registered response slot.
//   clock, reset_L        - clock (rising edge), async active-low reset
//   req_valid/req_ready   - per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b, req_op  - per-requester operands and opcode
//   resp_valid/resp_ready - response slot handshake
//   resp_id               - requester that produced the result
//   resp_flags            - {unord, gt, eq, lt}
//   resp_value            - MIN/MAX result, zero for CMP and reserved op
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer keeps its payload stable while valid is high and ready is
// low; ready never depends on a later acceptance. The response slot is free
// when empty or being drained this cycle, so drain and refill can share a cycle.
module fpu_cmp_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clock,
    input  logic                  reset_L,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  fp16_t [NUM_REQ-1:0]   req_a,
    input  fp16_t [NUM_REQ-1:0]   req_b,
    input  cmp_op_t [NUM_REQ-1:0] req_op,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [3:0]            resp_flags,
    output logic [15:0]           resp_value
);

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            resp_valid_q, resp_valid_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [3:0]      resp_flags_q, resp_flags_d;
    logic [15:0]     resp_value_q, resp_value_d;

    logic               slot_free;
    logic               arb_en;
    logic               xfer;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;

    fp16_t   op_a;
    fp16_t   op_b;
    cmp_op_t op_sel;
    logic    cmp_lt, cmp_eq, cmp_gt;
    logic    a_nan, b_nan;
    logic [3:0]  res_flags;
    logic [15:0] res_value;

    assign slot_free = ~resp_valid_q | resp_ready;
    // Gating with reset_L keeps every req_ready low while reset is held.
    assign arb_en    = slot_free & reset_L;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .en    (arb_en),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign req_ready = grant;
    // grant only ever selects a valid requester, so any grant is a transfer.
    assign xfer      = |grant;

    assign op_a   = req_a[grant_idx];
    assign op_b   = req_b[grant_idx];
    assign op_sel = req_op[grant_idx];

    fpuComp16 u_cmp (
        .a  (op_a),
        .b  (op_b),
        .lt (cmp_lt),
        .eq (cmp_eq),
        .gt (cmp_gt)
    );

    assign a_nan = fp16_is_nan(op_a);
    assign b_nan = fp16_is_nan(op_b);

    always_comb begin
        res_flags             = '0;
        res_value             = '0;
        res_flags[FLAG_LT]    = cmp_lt;
        res_flags[FLAG_EQ]    = cmp_eq;
        res_flags[FLAG_GT]    = cmp_gt;
        res_flags[FLAG_UNORD] = a_nan | b_nan;
        case (op_sel)
            OP_CMP: res_value = '0;
            OP_MIN: begin
                if (a_nan && b_nan)        res_value = FP16_QNAN;
                else if (a_nan)            res_value = op_b;
                else if (b_nan)            res_value = op_a;
                else if (cmp_lt || cmp_eq) res_value = op_a;
                else                       res_value = op_b;
            end
            OP_MAX: begin
                if (a_nan && b_nan)        res_value = FP16_QNAN;
                else if (a_nan)            res_value = op_b;
                else if (b_nan)            res_value = op_a;
                else if (cmp_gt || cmp_eq) res_value = op_a;
                else                       res_value = op_b;
            end
            default: begin
                // Reserved opcode completes with an all-zero result.
                res_flags = '0;
                res_value = '0;
            end
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_flags_d = resp_flags_q;
        resp_value_d = resp_value_q;
        if (xfer) begin
            rr_ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            resp_valid_d = 1'b1;
            resp_id_d    = grant_idx;
            resp_flags_d = res_flags;
            resp_value_d = res_value;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_flags_q <= '0;
            resp_value_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_flags_q <= resp_flags_d;
            resp_value_q <= resp_value_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_flags = resp_flags_q;
    assign resp_value = resp_value_q;

endmodule

// File: tb/tb_fpu_cmp_arbiter.sv
// Testbench for fpu_cmp_arbiter: directed steps plus a randomized phase,
// all checked against a behavioural model (value arithmetic + expected queue).
module tb_fpu_cmp_arbiter;
    import fpu_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int RW = IW + 4 + 16;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_L = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT (NUM_REQ=4) ----------------
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    fp16_t [N-1:0]   req_a;
    fp16_t [N-1:0]   req_b;
    cmp_op_t [N-1:0] req_op;
    logic            resp_valid;
    logic            resp_ready;
    logic [IW-1:0]   resp_id;
    logic [3:0]      resp_flags;
    logic [15:0]     resp_value;

    fpu_cmp_arbiter #(.NUM_REQ(N)) dut (
        .clock      (clock),
        .reset_L    (reset_L),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_flags (resp_flags),
        .resp_value (resp_value)
    );

    // ---------------- DUT (NUM_REQ=3) ----------------
    logic [2:0]    r3_valid;
    logic [2:0]    r3_ready;
    fp16_t [2:0]   r3_a;
    fp16_t [2:0]   r3_b;
    cmp_op_t [2:0] r3_op;
    logic          r3_resp_valid;
    logic          r3_resp_ready;
    logic [1:0]    r3_id;
    logic [3:0]    r3_flags;
    logic [15:0]   r3_value;

    fpu_cmp_arbiter #(.NUM_REQ(3)) dut3 (
        .clock      (clock),
        .reset_L    (reset_L),
        .req_valid  (r3_valid),
        .req_ready  (r3_ready),
        .req_a      (r3_a),
        .req_b      (r3_b),
        .req_op     (r3_op),
        .resp_valid (r3_resp_valid),
        .resp_ready (r3_resp_ready),
        .resp_id    (r3_id),
        .resp_flags (r3_flags),
        .resp_value (r3_value)
    );

    // ---------------- scoreboard / model state ----------------
    logic [RW-1:0] exp_q[$];
    int            m_ptr    = 0;
    int            m_last_g = -1;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    endfunction

    // Numeric value in units of 2^-24; infinities map beyond any finite value.
    function automatic longint fp_val(input logic [15:0] x);
        longint mag;
        if (x[14:10] == 5'h1F)     mag = longint'(1) <<< 50;
        else if (x[14:10] == 5'd0) mag = longint'(x[9:0]);
        else                       mag = longint'(1024 + x[9:0]) <<< (x[14:10] - 1);
        return x[15] ? -mag : mag;
    endfunction

    // Returns {flags[3:0], value[15:0]}.
    function automatic logic [19:0] ref_result(input logic [1:0] op, input logic [15:0] a,
                                               input logic [15:0] b);
        logic lt, eq, gt, un;
        logic [15:0] v;
        longint va, vb;
        lt = 0; eq = 0; gt = 0; v = 16'h0;
        un = is_nan(a) || is_nan(b);
        if (!un) begin
            if (a[14:0] == 15'd0 && b[14:0] == 15'd0) begin
                lt = a[15] && !b[15];
                gt = !a[15] && b[15];
                eq = (a[15] == b[15]);
            end else begin
                va = fp_val(a);
                vb = fp_val(b);
                lt = va < vb;
                eq = va == vb;
                gt = va > vb;
            end
        end
        if (op == 2'b01 || op == 2'b10) begin
            if (is_nan(a) && is_nan(b)) v = 16'h7E00;
            else if (is_nan(a))         v = b;
            else if (is_nan(b))         v = a;
            else if (op == 2'b01)       v = (lt || eq) ? a : b;
            else                        v = (gt || eq) ? a : b;
        end
        if (op == 2'b11) return 20'h0;
        return {un, gt, eq, lt, v};
    endfunction

    task automatic check_resp();
        logic [RW-1:0] e;
        chk("resp_valid", 32'(resp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("resp_id", 32'(resp_id), 32'(e[RW-1 -: IW]));
            chk("resp_flags", 32'(resp_flags), 32'(e[19:16]));
            chk("resp_value", 32'(resp_value), 32'(e[15:0]));
        end
    endtask

    // One clock: predict the grant, check req_ready, advance model, check response.
    // Called at posedge+1; returns at the next posedge+1.
    task automatic cycle();
        logic          slot_free;
        int            g;
        logic [N-1:0]  exp_ready;
        logic [19:0]   r;
        @(negedge clock);
        #1;
        slot_free = (exp_q.size() == 0) || resp_ready;
        g = -1;
        if (slot_free) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && req_valid[i]) g = i;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clock);
        if (exp_q.size() != 0 && resp_ready) void'(exp_q.pop_front());
        if (g >= 0) begin
            r = ref_result(2'(req_op[g]), req_a[g], req_b[g]);
            exp_q.push_back({IW'(g), r});
            m_ptr = (g + 1) % N;
        end
        m_last_g = g;
        #1;
        check_resp();
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        req_valid[i] = v;
        req_op[i]    = cmp_op_t'(op);
        req_a[i]     = a;
        req_b[i]     = b;
    endtask

    task automatic directed(input string tag, input logic [1:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [3:0] ef, input logic [15:0] ev);
        set_req(3, 1'b1, op, a, b);
        cycle();
        chk({tag, "_flags"}, 32'(resp_flags), 32'(ef));
        chk({tag, "_value"}, 32'(resp_value), 32'(ev));
        req_valid[3] = 1'b0;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 9))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7C00;
            3: return 16'hFC00;
            4: return 16'h7C00 | 16'($urandom_range(1, 1023));
            5: return 16'h3C00;
            6: return 16'hBC00;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        req_valid     = '0;
        req_a         = '0;
        req_b         = '0;
        req_op        = {N{OP_CMP}};
        resp_ready    = 1'b0;
        r3_valid      = '0;
        r3_a          = '0;
        r3_b          = '0;
        r3_op         = {3{OP_CMP}};
        r3_resp_ready = 1'b0;

        // Reset: outputs cleared and no grant even with requests present.
        req_valid = '1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_flags", 32'(resp_flags), 32'd0);
        chk("rst_resp_value", 32'(resp_value), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clock);
        #1 reset_L = 1'b1;
        @(posedge clock);
        #1;

        // Round-robin: all valid, MAX(-2.0, 1.0) -> 1.0, ids 0,1,2,3,0.
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b10, 16'hC000, 16'h3C00);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_id", 32'(resp_id), 32'(k % N));
            chk("rr_value", 32'(resp_value), 32'h3C00);
        end
        req_valid = '0;
        cycle();

        // Single request from requester 2: CMP(1.0, 2.0) -> lt.
        set_req(2, 1'b1, 2'b00, 16'h3C00, 16'h4000);
        cycle();
        chk("single_valid", 32'(resp_valid), 32'd1);
        chk("single_id", 32'(resp_id), 32'd2);
        chk("single_flags", 32'(resp_flags), 32'b0001);
        req_valid = '0;
        cycle();

        // Backpressure: slot held for 3 cycles, then drain and refill together.
        resp_ready = 1'b0;
        set_req(1, 1'b1, 2'b00, 16'h3C00, 16'h3C00);
        cycle();
        set_req(1, 1'b1, 2'b01, 16'h7E01, 16'h3C00);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_hold_flags", 32'(resp_flags), 32'b0010);
            chk("bp_hold_id", 32'(resp_id), 32'd1);
        end
        resp_ready = 1'b1;
        cycle();
        chk("bp_refill_valid", 32'(resp_valid), 32'd1);
        chk("bp_refill_value", 32'(resp_value), 32'h3C00);
        chk("bp_refill_flags", 32'(resp_flags), 32'b1000);
        req_valid = '0;
        cycle();

        // NaN, signed zero, infinity and reserved-op corner cases.
        directed("min_nan_a", 2'b01, 16'h7E01, 16'h3C00, 4'b1000, 16'h3C00);
        directed("max_nan_b", 2'b10, 16'h3C00, 16'hFC01, 4'b1000, 16'h3C00);
        directed("max_nan_nan", 2'b10, 16'h7E01, 16'hFC01, 4'b1000, 16'h7E00);
        directed("min_zeros", 2'b01, 16'h8000, 16'h0000, 4'b0001, 16'h8000);
        directed("max_zeros", 2'b10, 16'h8000, 16'h0000, 4'b0001, 16'h0000);
        directed("cmp_ninf_ninf", 2'b00, 16'hFC00, 16'hFC00, 4'b0010, 16'h0000);
        directed("cmp_inf_max", 2'b00, 16'h7C00, 16'h7BFF, 4'b0100, 16'h0000);
        directed("cmp_ninf_inf", 2'b00, 16'hFC00, 16'h7C00, 4'b0001, 16'h0000);
        directed("rsvd", 2'b11, 16'h3C00, 16'h4000, 4'b0000, 16'h0000);
        cycle();

        // Randomized traffic with backpressure and request withdrawal.
        for (int c = 0; c < 400; c++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || m_last_g == i) begin
                    set_req(i, ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)),
                            pick_operand(), pick_operand());
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            cycle();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        cycle();

        // Reset mid-operation: pending response dropped immediately.
        resp_ready = 1'b0;
        set_req(0, 1'b1, 2'b00, 16'h3C00, 16'h4000);
        cycle();
        req_valid = '0;
        chk("pre_rst_valid", 32'(resp_valid), 32'd1);
        #2 reset_L = 1'b0;
        #1;
        chk("async_rst_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        exp_q.delete();
        m_ptr = 0;
        @(negedge clock);
        #1 reset_L = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b00, 16'h3C00, 16'h3C00);
        cycle();
        chk("post_rst_first_id", 32'(resp_id), 32'd0);
        req_valid = '0;
        cycle();

        // NUM_REQ=3 instance: grant order 0,1,2,0.
        r3_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r3_op[i] = OP_MAX;
            r3_a[i]  = 16'hC000;
            r3_b[i]  = 16'h3C00;
        end
        r3_valid = '1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            chk("rr3_valid", 32'(r3_resp_valid), 32'd1);
            chk("rr3_id", 32'(r3_id), 32'(k % 3));
            chk("rr3_value", 32'(r3_value), 32'h3C00);
        end
        r3_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
